// File: rtl/bf_pair_buf.sv
// bf_pair_buf: reorders a natural-order frame of N complex samples into
// butterfly pairs (x[k], x[k+N/2]). The first half of each frame is parked
// in a HALF-entry buffer; each second-half sample is emitted together with
// its buffered partner one cycle after it is accepted.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Upstream: din_valid/din_ready. Downstream: dout_valid/dout_ready.
// A pair presented with dout_valid=1 stays stable until dout_ready=1.
module bf_pair_buf #(
    parameter int SIG = 1,
    parameter int INT = 3,
    parameter int FLT = 6,
    parameter int N   = 16,
    localparam int WIDTH = SIG + INT + FLT,
    localparam int HALF  = N / 2,
    localparam int AW    = $clog2(HALF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic signed [WIDTH-1:0] dout1_re,
    output logic signed [WIDTH-1:0] dout1_im,
    output logic signed [WIDTH-1:0] dout2_re,
    output logic signed [WIDTH-1:0] dout2_im,
    output logic [AW-1:0]           dout_idx,
    output logic                    dout_last,
    output logic                    state_dbg
);

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(HALF - 1);

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     cnt_nxt;
    logic              accept;
    logic [2*WIDTH-1:0] mem [HALF];
    logic [2*WIDTH-1:0] rd;

    assign state_dbg = (state == PAIR);
    assign rd        = mem[cnt];

    // Next-state, counter and upstream ready. During reset the FILL rule
    // applies to din_ready, but nothing is accepted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        din_ready = 1'b1;
        if (state == PAIR && !rst) begin
            din_ready = !dout_valid || dout_ready;
        end
        accept = din_valid && din_ready && !rst;
        if (accept) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                state_nxt = (state == FILL) ? PAIR : FILL;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // State register and frame position counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // First-half buffer; an entry is only overwritten after PAIR has read it,
    // so a stalled final pair never blocks the next frame's fill.
    always_ff @(posedge clk) begin
        if (accept && state == FILL) begin
            mem[cnt] <= {din_re, din_im};
        end
    end

    // Output pair register: load on a PAIR acceptance (replacing any pair
    // consumed this same cycle), otherwise clear valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_idx   <= '0;
            dout1_re   <= '0;
            dout1_im   <= '0;
            dout2_re   <= '0;
            dout2_im   <= '0;
        end else if (accept && state == PAIR) begin
            dout_valid <= 1'b1;
            dout_last  <= (cnt == CNT_LAST);
            dout_idx   <= cnt;
            dout1_re   <= rd[2*WIDTH-1:WIDTH];
            dout1_im   <= rd[WIDTH-1:0];
            dout2_re   <= din_re;
            dout2_im   <= din_im;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: doc/bf_pair_buf.md
BF_PAIR_BUF -- requirements
Module: bf_pair_buf

Interface
REQ-001 Parameter SIG, default 1: sign bits per component.
REQ-002 Parameter INT, default 3: integer bits per component.
REQ-003 Parameter FLT, default 6: fractional bits per component.
REQ-004 Parameter N, default 16: frame length in complex samples, a power of 2, at least 4.
REQ-005 Derived localparams: WIDTH = SIG+INT+FLT; HALF = N/2; AW = log2(HALF).
REQ-006 clk  in  1  the single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 din_valid  in  1  input sample valid.
REQ-009 din_ready  out  1  block accepts the sample this cycle.
REQ-010 din_re, din_im  in  WIDTH signed each  input sample in natural order.
REQ-011 dout_valid  out  1  output pair valid.
REQ-012 dout_ready  in  1  downstream butterfly consumes the pair.
REQ-013 dout1_re, dout1_im  out  WIDTH signed each  x[k], the first-half sample.
REQ-014 dout2_re, dout2_im  out  WIDTH signed each  x[k+HALF], the second-half sample.
REQ-015 dout_idx  out  AW  pair index k.
REQ-016 dout_last  out  1  asserted with the pair k = HALF-1.

Function
REQ-017 The block SHALL use an HALF-entry buffer of {re,im}, a two-state FSM {FILL, PAIR} and an AW-bit counter cnt.
REQ-018 A sample SHALL be accepted only on a rising edge where din_valid and din_ready are both 1.
REQ-019 In FILL, din_ready SHALL be 1, and each accepted sample SHALL be written to buf[cnt] with cnt incremented.
REQ-020 On acceptance in FILL with cnt = HALF-1, the block SHALL move to PAIR and set cnt to 0.
REQ-021 In PAIR, din_ready SHALL equal (!dout_valid || dout_ready), a combinational path from dout_ready.
REQ-022 On acceptance in PAIR, the output register SHALL load on the same edge: dout1 = buf[cnt], dout2 = din, dout_idx = cnt, dout_last = (cnt == HALF-1), dout_valid = 1; cnt SHALL then increment.
REQ-023 On acceptance in PAIR with cnt = HALF-1, the block SHALL return to FILL and set cnt to 0.
REQ-024 Latency SHALL be 1 cycle from acceptance of x[k+HALF] to dout_valid with that pair.
REQ-025 While dout_valid = 1 and dout_ready = 0, all dout_* SHALL hold stable.
REQ-026 On dout_valid & dout_ready with no new load that cycle, dout_valid SHALL clear next cycle; when a consume and a load occur together, the new pair SHALL replace the old one with no bubble.
REQ-027 Sustained throughput SHALL be one sample per cycle when din_valid = 1 and dout_ready = 1.
REQ-028 In FILL, a pending unconsumed pair from the previous frame SHALL NOT block acceptance, because buffer entries are overwritten only after they have been read.
REQ-029 Data SHALL pass through unmodified, with no growth, rounding or saturation; width growth belongs to the butterfly.
REQ-030 Gaps in din_valid SHALL be tolerated in both states without loss or reordering.

Reset
REQ-031 With rst = 1 at a rising edge, the block SHALL set state = FILL, cnt = 0, dout_valid = 0, dout_last = 0, dout_idx = 0, and all dout data = 0.
REQ-032 Buffer contents SHALL NOT be reset.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame and any pending output pair; the first sample accepted after reset SHALL be x[0] of a new frame.
REQ-034 While rst = 1, din_ready SHALL still follow the FILL rule (value 1), but no sample SHALL be accepted.

Verification
REQ-035 N=16, WIDTH=10, ramp x[n] = (n, -n) for n = 0..15, dout_ready = 1 -> 8 pairs ((k,-k),(k+8,-k-8)) with idx 0..7, each one cycle after x[k+8], dout_last only on idx 7.
REQ-036 Back-to-back frames with continuous valid and ready -> 16 pairs, no lost samples, din_ready stuck at 1.
REQ-037 dout_ready = 0 for 5 cycles during PAIR -> outputs held stable, din_ready = 0 in PAIR, no sample lost, pairs resume in order.
REQ-038 dout_ready = 0 on the idx-7 pair while the next frame streams in FILL -> 8 samples accepted, idx-7 pair held intact until consumed.
REQ-039 rst pulse after 11 samples -> dout_valid = 0 next cycle; a fresh ramp produces pairs from (0, 8).
REQ-040 Extreme values -512 and +511 with random din_valid gaps -> bit-exact pass-through, order preserved.
